// File: rtl/la_demuxi2_pkg.sv
// Shared definitions for the la_demuxi2 receive-side lane demultiplexer.
// Collect-state encoding used by the pair-assembly FSM.
package la_demuxi2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GOT0 = 2'b01,
    ST_GOT1 = 2'b10,
    ST_FULL = 2'b11
  } collect_state_e;

endpackage

// File: rtl/la_pairreg.sv
// Output valid/ready register for a reassembled lane pair.
// Loads only when empty or draining; the caller guarantees that ordering.
module la_pairreg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] load_z0,
  input  logic [DW-1:0] load_z1,
  output logic          out_valid,
  output logic [DW-1:0] z0,
  output logic [DW-1:0] z1
);

  logic          valid_q, valid_d;
  logic [DW-1:0] z0_q, z0_d;
  logic [DW-1:0] z1_q, z1_d;

  always_comb begin
    valid_d = valid_q;
    z0_d    = z0_q;
    z1_d    = z1_q;
    if (load) begin
      valid_d = 1'b1;
      z0_d    = load_z0;
      z1_d    = load_z1;
    end else if (valid_q && drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q <= 1'b0;
      z0_q    <= '0;
      z1_q    <= '0;
    end else begin
      valid_q <= valid_d;
      z0_q    <= z0_d;
      z1_q    <= z1_d;
    end
  end

  assign out_valid = valid_q;
  assign z0        = z0_q;
  assign z1        = z1_q;

endmodule

// File: rtl/la_demuxi2.sv
// Receive-side inverting 1:2 demux: collects lane-tagged beats into pairs
// and presents each pair through a registered valid/ready stage.
module la_demuxi2
  import la_demuxi2_pkg::*;
#(
  parameter int DW   = 8,
  parameter int INV  = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d,
  input  logic          s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] z0,
  output logic [DW-1:0] z1,
  output logic          err
);

  collect_state_e state_q, state_d;
  logic [DW-1:0]  lane0_q, lane0_d;
  logic [DW-1:0]  lane1_q, lane1_d;
  logic           err_q, err_d;

  logic           accept;
  logic           out_free;
  logic [DW-1:0]  cap;
  logic           load;
  logic [DW-1:0]  load_z0, load_z1;

  assign in_ready = (state_q != ST_FULL);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign cap      = (INV != 0) ? ~d : d;

  // The completing beat bypasses its lane register so a pair lands in z0/z1
  // one cycle after the last beat when the output stage can take it.
  always_comb begin
    state_d = state_q;
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    err_d   = err_q;
    load    = 1'b0;
    load_z0 = lane0_q;
    load_z1 = lane1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (s) begin
            lane1_d = cap;
            state_d = ST_GOT1;
          end else begin
            lane0_d = cap;
            state_d = ST_GOT0;
          end
        end
      end
      ST_GOT0: begin
        if (accept) begin
          if (!s) begin
            lane0_d = cap;
            err_d   = 1'b1;
          end else begin
            lane1_d = cap;
            if (out_free) begin
              load    = 1'b1;
              load_z1 = cap;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FULL;
            end
          end
        end
      end
      ST_GOT1: begin
        if (accept) begin
          if (s) begin
            lane1_d = cap;
            err_d   = 1'b1;
          end else begin
            lane0_d = cap;
            if (out_free) begin
              load    = 1'b1;
              load_z0 = cap;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FULL;
            end
          end
        end
      end
      ST_FULL: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      lane0_q <= '0;
      lane1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

  la_pairreg #(
    .DW(DW)
  ) u_pairreg (
    .clk      (clk),
    .nreset   (nreset),
    .load     (load),
    .drain    (out_ready),
    .load_z0  (load_z0),
    .load_z1  (load_z1),
    .out_valid(out_valid),
    .z0       (z0),
    .z1       (z1)
  );

endmodule
